// File: rtl/imem_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_loader: turns 32-bit host words into big-endian byte writes at A..A+3.
// Revision: 1.0
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              w_valid,
  input  logic [31:0]       w_data,
  output logic              w_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);
  // Word whose last byte sits at the highest memory address.
  localparam logic [ADDR_W-1:0] TOP_WORD   = ALIGN_MASK;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       checksum_q, checksum_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic [CNT_W-1:0]  rem_dec;

  assign rem_dec = remaining_q - CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    checksum_d  = checksum_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cur_addr_d  = base_addr & ALIGN_MASK;
          remaining_d = word_count;
          checksum_d  = 32'd0;
          overflow_d  = 1'b0;
          if (word_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ACCEPT;
          end
        end
      end

      ACCEPT: begin
        // Byte 0 is registered here so it is on the bus the cycle after the handshake.
        if (w_valid) begin
          word_d     = w_data;
          checksum_d = checksum_q + w_data;
          idx_d      = 2'd0;
          mem_we_d   = 1'b1;
          mem_addr_d = cur_addr_q;
          mem_data_d = w_data[31:24];
          state_d    = WRITE;
        end
      end

      WRITE: begin
        if (idx_q != 2'd3) begin
          idx_d      = idx_q + 2'd1;
          mem_we_d   = 1'b1;
          mem_addr_d = {cur_addr_q[ADDR_W-1:2], idx_q + 2'd1};
          case (idx_q)
            2'd0:    mem_data_d = word_q[23:16];
            2'd1:    mem_data_d = word_q[15:8];
            default: mem_data_d = word_q[7:0];
          endcase
        end else begin
          remaining_d = rem_dec;
          cur_addr_d  = cur_addr_q + WORD_BYTES;
          if (rem_dec == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (cur_addr_q == TOP_WORD) begin
            overflow_d = 1'b1;
            done_d     = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = ACCEPT;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      word_q      <= 32'd0;
      checksum_q  <= 32'd0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      word_q      <= word_d;
      checksum_q  <= checksum_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
    end
  end

  assign w_ready  = (state_q == ACCEPT);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign checksum = checksum_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_imem_loader: randomized loads against a byte-image reference model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [8:0]  base_addr;
  logic [7:0]  word_count;
  logic        w_valid;
  logic [31:0] w_data;
  logic        w_ready;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [7:0]  mem_data;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [31:0] checksum;

  imem_loader #(.ADDR_W(9), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .w_valid(w_valid), .w_data(w_data),
    .w_ready(w_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .busy(busy), .done(done), .overflow(overflow),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc;

  // Observed behaviour, collected away from the active edge.
  logic [7:0]  tb_mem [512];
  logic [16:0] wr_log [$];
  int          hs_q [$];
  int          done_q [$];
  int          bad_we, busy_cnt, rdy_cnt;
  logic        mon_clr = 1'b0;

  // Host words and reference-model results.
  logic [31:0] host_q [$];
  logic [16:0] exp_w [$];
  logic [31:0] exp_csum;
  bit          exp_ovf;
  int          exp_words;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_clr) begin
      wr_log.delete();
      hs_q.delete();
      done_q.delete();
      bad_we   <= 0;
      busy_cnt <= 0;
      rdy_cnt  <= 0;
      for (int i = 0; i < 512; i++) tb_mem[i] <= 8'hA5;
    end else begin
      if (mem_we) begin
        wr_log.push_back({mem_addr, mem_data});
        tb_mem[mem_addr] <= mem_data;
        if (w_ready || !busy) bad_we <= bad_we + 1;
      end
      if (w_valid && w_ready) hs_q.push_back(cyc);
      if (done) done_q.push_back(cyc);
      if (busy) busy_cnt <= busy_cnt + 1;
      if (w_ready) rdy_cnt <= rdy_cnt + 1;
    end
  end

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  // Reference: word i lands at (base rounded down to 4) + 4*i, MSB first;
  // a load stops early once a word ends at 511 with words still pending.
  task automatic model_run(input logic [8:0] base, input int cnt);
    int a;
    logic [31:0] w;
    a = int'(base) & ~3;
    exp_w.delete();
    exp_csum = 32'd0;
    exp_ovf = 1'b0;
    exp_words = 0;
    for (int i = 0; i < cnt; i++) begin
      w = host_q[i];
      exp_csum += w;
      exp_words++;
      for (int b = 0; b < 4; b++) exp_w.push_back({9'(a + b), w[31-8*b -: 8]});
      if (i < cnt - 1 && a + 4 > 511) begin
        exp_ovf = 1'b1;
        break;
      end
      a += 4;
    end
  endtask

  // Host driver: vmode 0 = valid held high, 1 = every other cycle, 2 = random.
  task automatic do_load(input logic [8:0] base, input logic [7:0] cnt,
                         input int vmode, output bit to);
    int hi, n;
    hi = 0; n = 0; to = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; word_count = cnt;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    forever begin
      w_valid = (hi < host_q.size()) &&
                (vmode == 0 || (vmode == 1 && n % 2 == 0) ||
                 (vmode == 2 && $urandom_range(1, 0) == 1));
      w_data = (hi < host_q.size()) ? host_q[hi] : $urandom;
      @(negedge clk);
      if (done) break;
      if (w_valid && w_ready) hi++;
      n++;
      if (n > 100 + 40 * int'(cnt)) begin
        to = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [54:0] v;
    reset_n = 1'b0; start = 1'b1; w_valid = 1'b1; w_data = 32'hDEADBEEF;
    base_addr = 9'h010; word_count = 8'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v = {w_ready, mem_we, mem_addr, mem_data, busy, done, overflow, checksum};
      n_checks++;
      if (v !== 55'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %h, expected 0", i, v);
      end
    end
    start = 1'b0; w_valid = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic test_single_word();
    bit to;
    clear_mon();
    host_q.delete(); host_q.push_back(32'h8C220004);
    do_load(9'h000, 8'd1, 0, to);
    model_run(9'h000, 1);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL single_timeout: load did not finish"); end
    n_checks++;
    if (wr_log.size() != exp_w.size()) begin
      n_fail++; $display("FAIL single_wr_count: got %0d, expected %0d", wr_log.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < wr_log.size(); i++) begin
      n_checks++;
      if (wr_log[i] !== exp_w[i]) begin
        n_fail++; $display("FAIL single_write[%0d]: got %h, expected %h", i, wr_log[i], exp_w[i]);
      end
    end
    n_checks++;
    if (checksum !== 32'h8C220004) begin
      n_fail++; $display("FAIL single_checksum: got %h, expected 8c220004", checksum);
    end
    n_checks++;
    if (done_q.size() != 1 || hs_q.size() != 1 || done_q[0] - hs_q[0] != 5) begin
      n_fail++; $display("FAIL single_done_latency: done %0d pulses, hs %0d, expected 1 pulse 5 cycles after hs",
                         done_q.size(), hs_q.size());
    end
    n_checks++;
    if ({tb_mem[0], tb_mem[1], tb_mem[2], tb_mem[3]} !== 32'h8C220004) begin
      n_fail++; $display("FAIL single_readback: got %h, expected 8c220004",
                         {tb_mem[0], tb_mem[1], tb_mem[2], tb_mem[3]});
    end
    n_checks++;
    if (busy !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: busy=%b overflow=%b, expected 0 0", busy, overflow);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int a;
    clear_mon();
    host_q.delete();
    for (int i = 0; i < 3; i++) host_q.push_back($urandom);
    do_load(9'h013, 8'd3, 1, to);
    model_run(9'h013, 3);
    n_checks++;
    if (to !== 1'b0 || hs_q.size() != 3) begin
      n_fail++; $display("FAIL bp_words: timeout=%b accepted %0d, expected 0 and 3", to, hs_q.size());
    end
    n_checks++;
    if (wr_log.size() != exp_w.size()) begin
      n_fail++; $display("FAIL bp_wr_count: got %0d, expected %0d", wr_log.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < wr_log.size(); i++) begin
      n_checks++;
      if (wr_log[i] !== exp_w[i]) begin
        n_fail++; $display("FAIL bp_write[%0d]: got %h, expected %h", i, wr_log[i], exp_w[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      a = 16 + 4 * i;
      n_checks++;
      if ({tb_mem[a], tb_mem[a+1], tb_mem[a+2], tb_mem[a+3]} !== host_q[i]) begin
        n_fail++; $display("FAIL bp_readback[%0d]: got %h, expected %h", i,
                           {tb_mem[a], tb_mem[a+1], tb_mem[a+2], tb_mem[a+3]}, host_q[i]);
      end
    end
    n_checks++;
    if (bad_we != 0) begin
      n_fail++; $display("FAIL bp_write_outside_write: got %0d, expected 0", bad_we);
    end
    n_checks++;
    if (checksum !== exp_csum) begin
      n_fail++; $display("FAIL bp_checksum: got %h, expected %h", checksum, exp_csum);
    end
  endtask

  task automatic test_overflow();
    bit to;
    int ready_seen, zero_writes;
    clear_mon();
    host_q.delete();
    host_q.push_back($urandom | 32'h01010101); host_q.push_back($urandom | 32'h01010101);
    do_load(9'h1FC, 8'd2, 0, to);
    model_run(9'h1FC, 2);
    n_checks++;
    if (to !== 1'b0 || exp_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_finish: timeout=%b model_ovf=%b, expected 0 1", to, exp_ovf);
    end
    n_checks++;
    if (wr_log.size() != exp_w.size()) begin
      n_fail++; $display("FAIL ovf_wr_count: got %0d, expected %0d", wr_log.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < wr_log.size(); i++) begin
      n_checks++;
      if (wr_log[i] !== exp_w[i]) begin
        n_fail++; $display("FAIL ovf_write[%0d]: got %h, expected %h", i, wr_log[i], exp_w[i]);
      end
    end
    n_checks++;
    if (overflow !== 1'b1 || done_q.size() != 1 || hs_q.size() != 1) begin
      n_fail++; $display("FAIL ovf_flags: overflow=%b done=%0d accepted=%0d, expected 1 1 1",
                         overflow, done_q.size(), hs_q.size());
    end
    ready_seen = 0;
    w_valid = 1'b1; w_data = host_q[1];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (w_ready) ready_seen++;
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    zero_writes = 0;
    foreach (wr_log[i]) if (wr_log[i][16:8] == 9'h000) zero_writes++;
    n_checks++;
    if (ready_seen != 0 || tb_mem[0] !== 8'hA5 || zero_writes != 0) begin
      n_fail++; $display("FAIL ovf_no_wrap: ready=%0d mem0=%h writes_at_0=%0d, expected 0 a5 0",
                         ready_seen, tb_mem[0], zero_writes);
    end
    n_checks++;
    if (overflow !== 1'b1 || checksum !== host_q[0]) begin
      n_fail++; $display("FAIL ovf_sticky: overflow=%b checksum=%h, expected 1 %h",
                         overflow, checksum, host_q[0]);
    end
  endtask

  task automatic test_empty();
    bit to;
    clear_mon();
    host_q.delete();
    do_load(9'($urandom_range(511, 0)), 8'd0, 0, to);
    n_checks++;
    if (to !== 1'b0 || done_q.size() != 1 || done_q[0] != start_cyc) begin
      n_fail++; $display("FAIL empty_done: timeout=%b pulses=%0d, expected one pulse the cycle after start",
                         to, done_q.size());
    end
    n_checks++;
    if (busy_cnt != 0 || rdy_cnt != 0 || wr_log.size() != 0) begin
      n_fail++; $display("FAIL empty_quiet: busy=%0d ready=%0d writes=%0d, expected 0 0 0",
                         busy_cnt, rdy_cnt, wr_log.size());
    end
    n_checks++;
    if (overflow !== 1'b0 || checksum !== 32'd0) begin
      n_fail++; $display("FAIL empty_clear: overflow=%b checksum=%h, expected 0 0", overflow, checksum);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    clear_mon();
    host_q.delete();
    for (int i = 0; i < 4; i++) host_q.push_back($urandom);
    do_load(9'h080, 8'd4, 0, to);
    model_run(9'h080, 4);
    n_checks++;
    if (to !== 1'b0 || hs_q.size() != 4) begin
      n_fail++; $display("FAIL b2b_words: timeout=%b accepted=%0d, expected 0 4", to, hs_q.size());
    end
    for (int i = 1; i < hs_q.size(); i++) begin
      n_checks++;
      if (hs_q[i] - hs_q[i-1] != 5) begin
        n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d cycles, expected 5", i, hs_q[i] - hs_q[i-1]);
      end
    end
    n_checks++;
    if (wr_log != exp_w || checksum !== exp_csum || bad_we != 0) begin
      n_fail++; $display("FAIL b2b_result: writes=%0d checksum=%h bad_we=%0d, expected %0d %h 0",
                         wr_log.size(), checksum, bad_we, exp_w.size(), exp_csum);
    end
  endtask

  task automatic test_random_loads();
    bit to;
    logic [8:0] base;
    int cnt;
    for (int k = 0; k < 6; k++) begin
      clear_mon();
      base = (k % 3 == 0) ? 9'(496 + $urandom_range(15, 0)) : 9'($urandom_range(511, 0));
      cnt = $urandom_range(5, 1);
      host_q.delete();
      for (int i = 0; i < cnt; i++) host_q.push_back($urandom);
      do_load(base, 8'(cnt), 2, to);
      model_run(base, cnt);
      n_checks++;
      if (to !== 1'b0 || wr_log != exp_w) begin
        n_fail++; $display("FAIL rnd%0d_writes: timeout=%b writes=%0d, expected 0 %0d (base %h cnt %0d)",
                           k, to, wr_log.size(), exp_w.size(), base, cnt);
      end
      n_checks++;
      if (checksum !== exp_csum || overflow !== exp_ovf || hs_q.size() != exp_words) begin
        n_fail++; $display("FAIL rnd%0d_status: checksum=%h ovf=%b words=%0d, expected %h %b %0d",
                           k, checksum, overflow, hs_q.size(), exp_csum, exp_ovf, exp_words);
      end
      n_checks++;
      if (done_q.size() != 1 || hs_q.size() == 0 || done_q[0] - hs_q[$] != 5) begin
        n_fail++; $display("FAIL rnd%0d_done: pulses=%0d, expected one pulse 5 cycles after last hs",
                           k, done_q.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n;
    logic [31:0] w0;
    logic [54:0] v;
    clear_mon();
    host_q.delete(); host_q.push_back($urandom | 32'h00800000); host_q.push_back($urandom);
    w0 = host_q[0];
    @(posedge clk); #1;
    start = 1'b1; base_addr = 9'h040; word_count = 8'd2;
    @(posedge clk); #1;
    start = 1'b0; w_valid = 1'b1; w_data = w0;
    n = 0;
    @(negedge clk);
    while (!w_ready && n < 20) begin @(negedge clk); n++; end
    n_checks++;
    if (w_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_handshake: w_ready=%b, expected 1", w_ready);
      w_valid = 1'b0;
      return;
    end
    @(posedge clk); #1 w_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 9'h042) begin
      n_fail++; $display("FAIL rstmid_byte2: we=%b addr=%h, expected 1 042", mem_we, mem_addr);
    end
    reset_n = 1'b0;
    #1;
    v = {w_ready, mem_we, mem_addr, mem_data, busy, done, overflow, checksum};
    n_checks++;
    if (v !== 55'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %h, expected 0", v);
    end
    @(negedge clk);
    @(posedge clk); #1;
    n_checks++;
    if (wr_log.size() != 2 || {tb_mem[64], tb_mem[65]} !== w0[31:16] ||
        {tb_mem[66], tb_mem[67]} !== 16'hA5A5) begin
      n_fail++; $display("FAIL rstmid_partial: writes=%0d mem=%h%h%h%h, expected 2 %h a5a5",
                         wr_log.size(), tb_mem[64], tb_mem[65], tb_mem[66], tb_mem[67], w0[31:16]);
    end
    reset_n = 1'b1;
    clear_mon();
    host_q.delete(); host_q.push_back($urandom); host_q.push_back($urandom);
    do_load(9'h100, 8'd2, 2, to);
    model_run(9'h100, 2);
    n_checks++;
    if (to !== 1'b0 || wr_log != exp_w || overflow !== 1'b0 || checksum !== exp_csum) begin
      n_fail++; $display("FAIL rstmid_reload: timeout=%b writes=%0d ovf=%b checksum=%h, expected 0 %0d 0 %h",
                         to, wr_log.size(), overflow, checksum, exp_w.size(), exp_csum);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; w_valid = 1'b0; w_data = 32'd0;
    base_addr = 9'd0; word_count = 8'd0;
    test_reset();
    test_single_word();
    test_backpressure();
    test_overflow();
    test_empty();
    test_back_to_back();
    test_random_loads();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Sequential writer for the byte-addressed instruction memory: accepts 32-bit instruction words from a host over a valid/ready stream and serializes each one into four big-endian byte writes at consecutive addresses. The instruction memory reads A..A+3 as one instruction, so this block produces exactly the layout the fetch path consumes. It sits between the boot/test host and the memory write port, ahead of CPU release.

## Interface

- ADDR_W, 9, byte-address width; the memory holds 2^ADDR_W bytes (512).
- CNT_W, 8, width of the word-count field.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a load; sampled only in IDLE.
- base_addr  in  ADDR_W  first byte address; bits [1:0] forced to 0 when latched.
- word_count  in  CNT_W  number of 32-bit words to load.
- w_valid  in  1  host word valid.
- w_data  in  32  host instruction word.
- w_ready  out  1  loader can take a word this cycle.
- mem_we  out  1  byte write enable to instruction memory.
- mem_addr  out  ADDR_W  byte write address.
- mem_data  out  8  byte write data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a load ends (normal, empty or overflow).
- overflow  out  1  sticky; set when a load runs past the top address; cleared by the next accepted start.
- checksum  out  32  modulo-2^32 sum of all words accepted in the current load; cleared by accepted start.

## Operation

- States: IDLE, ACCEPT, WRITE (byte index 0..3).
- IDLE: w_ready=0, mem_we=0. On start=1, latch cur_addr=base_addr&~3 and remaining=word_count, clear checksum and overflow.
  - word_count==0: stay in IDLE; done pulses the next cycle.
  - Otherwise go to ACCEPT.
- ACCEPT: w_ready=1. On w_valid&w_ready, latch w_data, checksum+=w_data, go to WRITE with idx=0. If w_valid=0, wait indefinitely.
- WRITE: mem_we=1, mem_addr=cur_addr+idx, mem_data=word[31-8*idx -: 8] (idx0 gives [31:24]). w_ready=0. idx increments each cycle.
- After idx=3:
  - Decrement remaining and add 4 to cur_addr.
  - remaining now 0: done pulse, go to IDLE.
  - remaining nonzero and the byte just written was at address 2^ADDR_W-1: no wrap to 0. Set overflow, pulse done, go to IDLE. Remaining host words are not accepted.
  - Otherwise go back to ACCEPT.
- start is ignored while busy=1.
- Reset (any time, including mid-WRITE) does the following:
  - Goes to IDLE.
  - All outputs go to 0: w_ready, mem_we, mem_addr, mem_data, busy, done, overflow, checksum.
  - Internal counters clear.
  - A partially written word stays partially written; the block does not clean up memory.

## Timing

- start sampled at edge N: busy=1 and w_ready=1 from cycle N+1.
- Handshake at edge K: byte0 write occupies cycle K+1 through byte3 in cycle K+4. The write commits on the edge ending each cycle.
- After the final byte (cycle K+4): done=1 and busy=0 in cycle K+5.
- Steady-state throughput is one word per 5 cycles with w_valid held high.
- Empty load: start at edge N, then done=1 in cycle N+1, busy stays 0.
- mem_we is never high in IDLE or ACCEPT.
- mem_addr/mem_data hold their last values when mem_we=0.

## Test plan

- Reset values: hold reset_n=0, drive start=1 and w_valid=1. All outputs stay 0, no mem_we.
- Single word: base_addr=0x000, word_count=1, w_data=0x8C220004.
  - Bytes 0x8C, 0x22, 0x00, 0x04 are written at addresses 0..3 in order.
  - done pulses 5 cycles after the handshake.
  - checksum=0x8C220004.
  - Reading the memory back at A=0 returns 0x8C220004.
- Back-pressure and alignment: base_addr=0x013 (latched as 0x010), word_count=3, w_valid toggled every other cycle.
  - Words land at 0x010, 0x014, 0x018.
  - No writes occur while waiting in ACCEPT.
  - checksum equals the sum of the three words.
- Overflow: base_addr=0x1FC, word_count=2.
  - The first word is written at 0x1FC..0x1FF.
  - overflow=1 and done pulses.
  - The second word is never accepted (w_ready stays 0).
  - Address 0x000 is untouched.
- Empty load: word_count=0. done pulses the next cycle, w_ready stays 0, and no writes occur.
- Reset mid-operation: assert reset_n=0 during byte index 2.
  - Outputs clear immediately.
  - Only bytes 0-1 of that word are in memory.
  - A new start after release loads normally, with overflow and checksum cleared.
